// File: rtl/vga_sync_decoder_if.sv
// Signal bundle between a VGA timing source and vga_sync_decoder.
// The master drives sync and colour; the slave (decoder) returns recovered pixels and status.
interface vga_sync_decoder_if;
   logic        HS_IN;
   logic        VS_IN;
   logic [11:0] COLOUR_IN;
   logic        PIX_VALID;
   logic [9:0]  X_OUT;
   logic [8:0]  Y_OUT;
   logic [11:0] COLOUR_OUT;
   logic        LOCKED;
   logic        FRAME_DONE;
   logic [15:0] FRAME_COUNT;
   logic        H_ERR;
   logic        V_ERR;
   logic [7:0]  ERR_COUNT;

   modport master (
      output HS_IN, VS_IN, COLOUR_IN,
      input  PIX_VALID, X_OUT, Y_OUT, COLOUR_OUT, LOCKED, FRAME_DONE,
      input  FRAME_COUNT, H_ERR, V_ERR, ERR_COUNT
   );

   modport slave (
      input  HS_IN, VS_IN, COLOUR_IN,
      output PIX_VALID, X_OUT, Y_OUT, COLOUR_OUT, LOCKED, FRAME_DONE,
      output FRAME_COUNT, H_ERR, V_ERR, ERR_COUNT
   );
endinterface

// File: rtl/vga_sync_decoder.sv
// Sink-side VGA decoder: recovers pixel coordinates and colour from HS/VS/colour,
// checks line and frame timing, and reports lock, frame and error status.
module vga_sync_decoder #(
   parameter int unsigned CLKS_PER_PIXEL = 4,
   parameter int unsigned SAMPLE_PHASE   = 2,
   parameter int unsigned H_TOTAL        = 800,
   parameter int unsigned H_SYNC         = 96,
   parameter int unsigned H_ACT_START    = 144,
   parameter int unsigned H_ACT_END      = 784,
   parameter int unsigned V_TOTAL        = 521,
   parameter int unsigned V_SYNC         = 2,
   parameter int unsigned V_ACT_START    = 31,
   parameter int unsigned V_ACT_END      = 511
) (
   input logic               CLK,
   input logic               RESET,
   vga_sync_decoder_if.slave bus
);
   localparam int PH_W = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
   localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLKS_PER_PIXEL - 1);
   localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(SAMPLE_PHASE);
   localparam logic [PH_W-1:0] PH_ONE    = PH_W'(1);
   localparam logic [PH_W-1:0] PH_ZERO   = PH_W'(0);
   localparam logic [9:0] CNT_MAX     = 10'h3FF;
   localparam logic [9:0] H_LINE_END  = 10'(H_TOTAL);
   localparam logic [9:0] H_SYNC_C    = 10'(H_SYNC);
   localparam logic [9:0] H_ACT_S_C   = 10'(H_ACT_START);
   localparam logic [9:0] H_ACT_E_C   = 10'(H_ACT_END);
   localparam logic [9:0] V_LAST_C    = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_SYNC_C    = 10'(V_SYNC);
   localparam logic [9:0] V_ACT_S_C   = 10'(V_ACT_START);
   localparam logic [9:0] V_ACT_E_C   = 10'(V_ACT_END);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_HLOCK  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
   logic [PH_W-1:0] phase_q, phase_d;
   logic [9:0]      hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic            pix_valid_q, pix_valid_d;
   logic [9:0]      x_q, x_d;
   logic [8:0]      y_q, y_d;
   logic [11:0]     colour_q, colour_d;
   logic            frame_done_q, frame_done_d;
   logic [15:0]     frame_count_q, frame_count_d;
   logic            h_err_q, h_err_d, v_err_q, v_err_d;
   logic [7:0]      err_count_q, err_count_d;

   logic hs_fall, hs_rise, vs_fall, vs_rise, phase_last;
   logic h_err, v_err, frame_ok, sample;
   logic [8:0] err_sum;

   always_comb begin
      hs_prev_d  = bus.HS_IN;
      vs_prev_d  = bus.VS_IN;
      hs_fall    = hs_prev_q & ~bus.HS_IN;
      hs_rise    = ~hs_prev_q & bus.HS_IN;
      vs_fall    = vs_prev_q & ~bus.VS_IN;
      vs_rise    = ~vs_prev_q & bus.VS_IN;
      phase_last = (phase_q == PH_LAST);
      if (hs_fall) begin
         phase_d = PH_ONE;
         hcnt_d  = 10'd0;
      end else begin
         phase_d = phase_last ? PH_ZERO : phase_q + PH_ONE;
         hcnt_d  = (phase_last && hcnt_q != CNT_MAX) ? hcnt_q + 10'd1 : hcnt_q;
      end
      if (hs_fall && vs_fall) begin
         vcnt_d = 10'd0;
      end else if (hs_fall && vcnt_q != CNT_MAX) begin
         vcnt_d = vcnt_q + 10'd1;
      end else begin
         vcnt_d = vcnt_q;
      end
   end

   // A correct HS fall arrives the clock after the last phase of pixel H_TOTAL-1,
   // when the counters already read (H_TOTAL, 0). VS may rise together with the
   // HS fall that opens line V_SYNC, so the rise is judged on the updated line count.
   always_comb begin
      h_err = (state_q != ST_SEARCH) &&
              ((hs_fall && !(hcnt_q == H_LINE_END && phase_q == PH_ZERO)) ||
               (hs_rise && !(hcnt_q == H_SYNC_C && phase_q == PH_ZERO)));
      v_err = (state_q == ST_LOCKED) &&
              ((vs_fall && !(hs_fall && vcnt_q == V_LAST_C)) ||
               (vs_rise && vcnt_d != V_SYNC_C));
      frame_ok = (state_q == ST_LOCKED) && vs_fall && !v_err;
      state_d = state_q;
      case (state_q)
         ST_SEARCH: begin
            if (hs_fall) state_d = ST_HLOCK;
            else         state_d = ST_SEARCH;
         end
         ST_HLOCK: begin
            if (h_err)                   state_d = ST_SEARCH;
            else if (hs_fall && vs_fall) state_d = ST_LOCKED;
            else                         state_d = ST_HLOCK;
         end
         ST_LOCKED: begin
            if (h_err || v_err) state_d = ST_SEARCH;
            else                state_d = ST_LOCKED;
         end
         default: state_d = ST_SEARCH;
      endcase
   end

   always_comb begin
      sample = (state_q == ST_LOCKED) && (phase_q == PH_SAMPLE) &&
               (hcnt_q >= H_ACT_S_C) && (hcnt_q < H_ACT_E_C) &&
               (vcnt_q >= V_ACT_S_C) && (vcnt_q < V_ACT_E_C);
      pix_valid_d = sample;
      if (sample) begin
         x_d      = hcnt_q - H_ACT_S_C;
         y_d      = 9'(vcnt_q - V_ACT_S_C);
         colour_d = bus.COLOUR_IN;
      end else begin
         x_d      = x_q;
         y_d      = y_q;
         colour_d = colour_q;
      end
      frame_done_d  = frame_ok;
      frame_count_d = frame_count_q + {15'd0, frame_ok};
      h_err_d       = h_err;
      v_err_d       = v_err;
      err_sum       = {1'b0, err_count_q} + {8'd0, h_err} + {8'd0, v_err};
      err_count_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q       <= ST_SEARCH;
         hs_prev_q     <= 1'b1;
         vs_prev_q     <= 1'b1;
         phase_q       <= PH_ZERO;
         hcnt_q        <= 10'd0;
         vcnt_q        <= 10'd0;
         pix_valid_q   <= 1'b0;
         x_q           <= 10'd0;
         y_q           <= 9'd0;
         colour_q      <= 12'd0;
         frame_done_q  <= 1'b0;
         frame_count_q <= 16'd0;
         h_err_q       <= 1'b0;
         v_err_q       <= 1'b0;
         err_count_q   <= 8'd0;
      end else begin
         state_q       <= state_d;
         hs_prev_q     <= hs_prev_d;
         vs_prev_q     <= vs_prev_d;
         phase_q       <= phase_d;
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         pix_valid_q   <= pix_valid_d;
         x_q           <= x_d;
         y_q           <= y_d;
         colour_q      <= colour_d;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
         h_err_q       <= h_err_d;
         v_err_q       <= v_err_d;
         err_count_q   <= err_count_d;
      end
   end

   assign bus.PIX_VALID   = pix_valid_q;
   assign bus.X_OUT       = x_q;
   assign bus.Y_OUT       = y_q;
   assign bus.COLOUR_OUT  = colour_q;
   assign bus.LOCKED      = (state_q == ST_LOCKED);
   assign bus.FRAME_DONE  = frame_done_q;
   assign bus.FRAME_COUNT = frame_count_q;
   assign bus.H_ERR       = h_err_q;
   assign bus.V_ERR       = v_err_q;
   assign bus.ERR_COUNT   = err_count_q;
endmodule
